// File: rtl/reg_bank_rf_pkg.sv
// Shared constants and types for the register bank register file.
// Default geometry matches the operand-latch and writeback blocks.
package reg_bank_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_N_RD   = 2;
  localparam int RD_LAT     = 1;

  // Where a read port takes its next word from.
  typedef enum logic [1:0] {
    SRC_MEM    = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ZERO   = 2'd2
  } rdSrc_e;

endpackage

// File: rtl/reg_bank_rf_if.sv
// Write/read bus of the register file.
// The writeback stage and the operand latches sit on the master side.
interface reg_bank_rf_if
  import reg_bank_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [N_RD-1:0]          rd_en;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic [N_RD-1:0]          rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/reg_bank_rf_read_port.sv
// One registered read port: word select, write bypass and r0 gating,
// with rd_data/rd_valid captured on the clock edge.
module rf_read_port
  import reg_bank_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   memFlat_i,
  input  logic                            wrEn_i,
  input  logic [ADDR_W-1:0]               wrAddr_i,
  input  logic [DATA_W-1:0]               wrData_i,
  input  logic                            rdEn_i,
  input  logic [ADDR_W-1:0]               rdAddr_i,
  output logic [DATA_W-1:0]               rdData_o,
  output logic                            rdValid_o
);

  rdSrc_e            src;
  logic [DATA_W-1:0] rdData_d, rdData_q;
  logic              rdValid_d, rdValid_q;

  // r0 gating outranks bypass so a dropped r0 write can never leak through.
  always_comb begin
    src       = SRC_MEM;
    rdData_d  = rdData_q;
    rdValid_d = rdEn_i;
    if (ZERO_R0 != 0 && rdAddr_i == '0) begin
      src = SRC_ZERO;
    end else if (BYPASS != 0 && wrEn_i && wrAddr_i == rdAddr_i) begin
      src = SRC_BYPASS;
    end
    if (rdEn_i) begin
      unique case (src)
        SRC_ZERO:   rdData_d = '0;
        SRC_BYPASS: rdData_d = wrData_i;
        default:    rdData_d = memFlat_i[rdAddr_i*DATA_W +: DATA_W];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign rdData_o  = rdData_q;
  assign rdValid_o = rdValid_q;

endmodule

// File: rtl/reg_bank_rf.sv
// Multi-port register file: flat storage with one write port and N_RD
// registered read ports, each built from an rf_read_port instance.
module reg_bank_rf
  import reg_bank_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = DEF_N_RD,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic        clk,
  input  logic        reset,
  reg_bank_rf_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH*DATA_W-1:0] mem_d, mem_q;
  logic [DATA_W-1:0]       portData [N_RD];
  logic                    portValid [N_RD];
  logic                    wrDrop;

  assign wrDrop = (ZERO_R0 != 0) && (bus.wr_addr == '0);

  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en && !wrDrop) begin
      mem_d[bus.wr_addr*DATA_W +: DATA_W] = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Ports see pre-write storage; bypass is resolved inside each port.
  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS),
      .ZERO_R0(ZERO_R0)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .memFlat_i(mem_q),
      .wrEn_i   (bus.wr_en),
      .wrAddr_i (bus.wr_addr),
      .wrData_i (bus.wr_data),
      .rdEn_i   (bus.rd_en[g]),
      .rdAddr_i (bus.rd_addr[g*ADDR_W +: ADDR_W]),
      .rdData_o (portData[g]),
      .rdValid_o(portValid[g])
    );
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    for (int i = 0; i < N_RD; i++) begin
      bus.rd_data[i*DATA_W +: DATA_W] = portData[i];
      bus.rd_valid[i]                 = portValid[i];
    end
  end

endmodule

// File: tb/tb_reg_bank_rf.sv
// Directed and model-checked bench for reg_bank_rf: a 16x32 two-port bypassing
// instance and a 32x32 three-port non-bypassing instance with hardwired r0.
module tb_reg_bank_rf;

  logic clk = 1'b0;
  logic resetA = 1'b1;
  logic resetB = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  reg_bank_rf_if #(.DATA_W(32), .ADDR_W(4), .N_RD(2)) busA ();
  reg_bank_rf_if #(.DATA_W(32), .ADDR_W(5), .N_RD(3)) busB ();

  reg_bank_rf #(.DATA_W(32), .ADDR_W(4), .N_RD(2), .BYPASS(1), .ZERO_R0(0)) dutA (
    .clk  (clk),
    .reset(resetA),
    .bus  (busA.slave)
  );

  reg_bank_rf #(.DATA_W(32), .ADDR_W(5), .N_RD(3), .BYPASS(0), .ZERO_R0(1)) dutB (
    .clk  (clk),
    .reset(resetB),
    .bus  (busB.slave)
  );

  // Every comparison goes through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulusA(input logic r, input logic we, input logic [3:0] wa,
                                input logic [31:0] wd, input logic [1:0] re, input logic [7:0] ra);
    resetA        = r;
    busA.wr_en    = we;
    busA.wr_addr  = wa;
    busA.wr_data  = wd;
    busA.rd_en    = re;
    busA.rd_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusB(input logic r, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [2:0] re, input logic [14:0] ra);
    resetB        = r;
    busB.wr_en    = we;
    busB.wr_addr  = wa;
    busB.wr_data  = wd;
    busB.rd_en    = re;
    busB.rd_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model [32];
  logic [31:0] expData [3];

  initial begin
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  re;
    logic [14:0] ra;
    logic [4:0]  pa;

    busA.wr_en = 1'b0; busA.wr_addr = '0; busA.wr_data = '0; busA.rd_en = '0; busA.rd_addr = '0;
    busB.wr_en = 1'b0; busB.wr_addr = '0; busB.wr_data = '0; busB.rd_en = '0; busB.rd_addr = '0;

    // ---------------- Instance A: BYPASS=1, ZERO_R0=0, 16x32, 2 ports
    applyStimulusA(1'b1, 1'b0, 4'd0, 32'h0, 2'b11, 8'h00);
    applyStimulusA(1'b1, 1'b0, 4'd0, 32'h0, 2'b11, 8'h00);
    checkOutput("A.reset.valid", 128'(busA.rd_valid), 128'(2'b00));
    checkOutput("A.reset.data", 128'(busA.rd_data), 128'h0);

    for (int a = 0; a < 16; a++) begin
      applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b11, {4'(15 - a), 4'(a)});
      checkOutput($sformatf("A.clr.r%0d.valid", a), 128'(busA.rd_valid), 128'(2'b11));
      checkOutput($sformatf("A.clr.r%0d.data", a), 128'(busA.rd_data), 128'h0);
    end
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b00, 8'h00);
    checkOutput("A.idle.valid", 128'(busA.rd_valid), 128'(2'b00));

    applyStimulusA(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 2'b00, 8'h00);
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b01, 8'h05);
    checkOutput("A.r5.data", 128'(busA.rd_data[31:0]), 128'hDEADBEEF);
    checkOutput("A.r5.valid", 128'(busA.rd_valid), 128'(2'b01));

    applyStimulusA(1'b0, 1'b1, 4'd7, 32'h11111111, 2'b00, 8'h00);
    applyStimulusA(1'b0, 1'b1, 4'd7, 32'h22222222, 2'b01, 8'h07);
    checkOutput("A.bypass.data", 128'(busA.rd_data[31:0]), 128'h22222222);
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b01, 8'h07);
    checkOutput("A.after.bypass", 128'(busA.rd_data[31:0]), 128'h22222222);

    applyStimulusA(1'b0, 1'b1, 4'd0, 32'hFFFFFFFF, 2'b00, 8'h00);
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b11, 8'h00);
    checkOutput("A.r0.data", 128'(busA.rd_data), 128'(64'hFFFFFFFF_FFFFFFFF));

    applyStimulusA(1'b0, 1'b1, 4'd3, 32'hA5A5A5A5, 2'b00, 8'h00);
    applyStimulusA(1'b0, 1'b1, 4'd12, 32'h5A5A5A5A, 2'b00, 8'h00);
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b11, {4'd12, 4'd3});
    checkOutput("A.indep.data", 128'(busA.rd_data), 128'(64'h5A5A5A5A_A5A5A5A5));
    checkOutput("A.indep.valid", 128'(busA.rd_valid), 128'(2'b11));
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b00, {4'd5, 4'd7});
    checkOutput("A.hold.data", 128'(busA.rd_data), 128'(64'h5A5A5A5A_A5A5A5A5));
    checkOutput("A.hold.valid", 128'(busA.rd_valid), 128'(2'b00));

    applyStimulusA(1'b1, 1'b1, 4'd9, 32'h00001234, 2'b11, {4'd9, 4'd9});
    checkOutput("A.midrst.valid", 128'(busA.rd_valid), 128'(2'b00));
    checkOutput("A.midrst.data", 128'(busA.rd_data), 128'h0);
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b00, 8'h00);
    checkOutput("A.postrst.valid", 128'(busA.rd_valid), 128'(2'b00));
    applyStimulusA(1'b0, 1'b0, 4'd0, 32'h0, 2'b11, {4'd3, 4'd9});
    checkOutput("A.postrst.data", 128'(busA.rd_data), 128'h0);
    checkOutput("A.resume.valid", 128'(busA.rd_valid), 128'(2'b11));

    // ---------------- Instance B: BYPASS=0, ZERO_R0=1, 32x32, 3 ports
    applyStimulusB(1'b1, 1'b0, 5'd0, 32'h0, 3'b000, 15'h0);
    checkOutput("B.reset.valid", 128'(busB.rd_valid), 128'(3'b000));
    checkOutput("B.reset.data", 128'(busB.rd_data), 128'h0);

    applyStimulusB(1'b0, 1'b1, 5'd7, 32'h11111111, 3'b000, 15'h0);
    applyStimulusB(1'b0, 1'b1, 5'd7, 32'h22222222, 3'b111, {5'd7, 5'd7, 5'd7});
    checkOutput("B.nobypass.data", 128'(busB.rd_data), 128'(96'h11111111_11111111_11111111));
    checkOutput("B.nobypass.valid", 128'(busB.rd_valid), 128'(3'b111));
    applyStimulusB(1'b0, 1'b0, 5'd0, 32'h0, 3'b001, 15'd7);
    checkOutput("B.after.write", 128'(busB.rd_data[31:0]), 128'h22222222);

    applyStimulusB(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 3'b000, 15'h0);
    applyStimulusB(1'b0, 1'b0, 5'd0, 32'h0, 3'b111, 15'h0);
    checkOutput("B.r0.data", 128'(busB.rd_data), 128'h0);
    checkOutput("B.r0.valid", 128'(busB.rd_valid), 128'(3'b111));

    // Random traffic against a reference memory; old data wins on collisions.
    applyStimulusB(1'b1, 1'b0, 5'd0, 32'h0, 3'b000, 15'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int p = 0; p < 3; p++) expData[p] = 32'h0;
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      re = 3'($urandom_range(0, 7));
      ra = 15'($urandom);
      if ($urandom_range(0, 3) == 0) ra[4:0] = wa;
      for (int p = 0; p < 3; p++) begin
        pa = ra[p*5 +: 5];
        if (re[p]) expData[p] = (pa == 5'd0) ? 32'h0 : model[pa];
      end
      applyStimulusB(1'b0, we, wa, wd, re, ra);
      for (int p = 0; p < 3; p++) begin
        checkOutput($sformatf("B.rand%0d.p%0d.data", c, p), 128'(busB.rd_data[p*32 +: 32]), 128'(expData[p]));
      end
      checkOutput($sformatf("B.rand%0d.valid", c), 128'(busB.rd_valid), 128'(re));
      if (we && wa != 5'd0) model[wa] = wd;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
